stack_ctrl: RTL and testbench
=============================

# stack_ctrl

Hardware stack sequencer between the control unit and data memory. Accepts push/pop requests with a 16-bit operand, generates the memory write/read cycles for a descending stack, and returns `push_done`/`pop_done` pulses plus the popped word. The control unit uses it for operand spills and for return addresses on JMP/RET.

## Interface
- `DATA_W`, 16, stack word width
- `ADDR_W`, 10, memory address width
- `STACK_BASE`, 10'h3FF, address of the first (bottom) slot; the stack grows toward lower addresses
- `DEPTH`, 64, number of slots; power of two, at most 2^ADDR_W
- `clk`  in  1  single clock, rising edge
- `rst_b`  in  1  asynchronous reset, **active-high**; the port name is kept for consistency
- `push_req`  in  1  push request; level, held until `push_done`
- `push_data`  in  DATA_W  word to push; sampled when the push is accepted
- `pop_req`  in  1  pop request; level, held until `pop_done`
- `clear`  in  1  empties the stack; acted on in IDLE only
- `mem_rdata`  in  DATA_W  memory read data; valid one cycle after `mem_re`
- `mem_we`  out  1  memory write strobe
- `mem_re`  out  1  memory read strobe
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `pop_out`  out  DATA_W  last popped word; holds until the next successful pop
- `push_done`  out  1  one-cycle completion pulse
- `pop_done`  out  1  one-cycle completion pulse
- `level`  out  log2(DEPTH)+1  current occupancy
- `empty`, `full`  out  1  occupancy flags
- `err`  out  1  one-cycle pulse on overflow or underflow

## Operation
- **FSM states:** IDLE, WRITE, READ, WAIT_RD, DONE.
- **IDLE:**
  - `clear` has top priority: `level` goes to 0 and the state stays IDLE.
  - Otherwise `push_req` is accepted next; it wins over `pop_req` when both are high.
  - Otherwise `pop_req` is accepted.
- **Push accept:** latch `push_data` and go to WRITE.
- **WRITE:**
  - `mem_we`=1, `mem_addr`=STACK_BASE−level, `mem_wdata`=latched data.
  - `level`+1 at the end of the cycle, then go to DONE.
- **Pop accept:** go to READ.
- **READ:**
  - `mem_re`=1, `mem_addr`=STACK_BASE−(level−1).
  - `level`−1 at the end of the cycle, then go to WAIT_RD.
- **WAIT_RD:** capture `mem_rdata` into `pop_out`, then go to DONE.
- **DONE:**
  - Pulse the `push_done` or `pop_done` matching the operation, then return to IDLE.
  - A request still high in the DONE cycle is ignored; it is re-evaluated in IDLE on the next cycle.
- **Outside IDLE:** requests and `clear` are ignored.
- **Flags:** `empty` = (level==0); `full` = (level==DEPTH). Both are combinational from `level`.
- **Address arithmetic:** ADDR_W-bit, modulo 2^ADDR_W.

## Timing
- **Reset values:** state IDLE, `level` 0, and every output 0 except `empty`=1. `pop_out` also resets to 0.
- **Push latency:** accept edge 0; WRITE in cycle 1; `push_done` in cycle 2.
- **Pop latency:** accept edge 0; READ in cycle 1; WAIT_RD in cycle 2; `pop_done` in cycle 3. `pop_out` is valid in the same cycle as `pop_done`.
- **Throughput:** back-to-back operations are separated by at least one IDLE cycle.
- **Reset mid-operation:** aborts immediately and returns to reset values. No done pulse is produced and memory contents are not touched.

## Configuration
- Macro: `STACK_CHECK_EN`.
- **Defined:**
  - Push while `full`: skip WRITE (no `mem_we`), go directly to DONE, and pulse `err` together with `push_done`. `level` is unchanged.
  - Pop while `empty`: skip READ/WAIT_RD (no `mem_re`) and pulse `err` together with `pop_done`. `pop_out` and `level` are unchanged.
- **Undefined:**
  - No checks. `level` counts modulo DEPTH, and addresses wrap within the DEPTH-slot window.
  - `err` and `full` are tied to 0.

## Structure
- **Shared package `stack_pkg`:** the state enum, and the defaults for DATA_W, ADDR_W, STACK_BASE and DEPTH.
- **Sub-module `stack_ptr`:** the occupancy counter with inc/dec/clear inputs and the `level`/`empty`/`full` outputs. The FSM and memory interface stay in `stack_ctrl`.

## Test plan
- **Single round trip:** push 16'hBEEF from reset.
  - Expect `mem_we` at addr 10'h3FF and `push_done` 2 cycles after accept.
  - Then pop: expect `mem_re` at 10'h3FF, `pop_out`=16'hBEEF with `pop_done` 3 cycles after accept, and `level` back to 0.
- **LIFO order:** push 1, 2, 3 (addresses 3FF, 3FE, 3FD), then pop 3 times.
  - Expect `pop_out` to be 3, 2, 1.
  - Expect `empty`=1 at the end.
- **Simultaneous requests:** `push_req` and `pop_req` high together in IDLE.
  - Push is served first, then the pop.
  - The pop returns the just-pushed word.
- **Overflow/underflow with `STACK_CHECK_EN`:**
  - 64 pushes give `full`=1. A 65th push gives `err`+`push_done` with no `mem_we`.
  - A pop on an empty stack gives `err`+`pop_done` with no `mem_re`.
- **Reset mid-pop:** assert `rst_b` during WAIT_RD.
  - No `pop_done`; `level`=0 and `pop_out`=0.
  - A following push behaves as from reset.
- **Clear:** push 5 words, then pulse `clear` in IDLE.
  - Expect `level`=0 and `empty`=1.
  - The next push writes 10'h3FF.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared types and default parameters for the stack sequencer.
// Overflow/underflow checking is selected by the STACK_CHECK_EN macro.
package stack_pkg;

   localparam int DATA_W_DEF     = 16;
   localparam int ADDR_W_DEF     = 10;
   localparam int DEPTH_DEF      = 64;
   localparam int STACK_BASE_DEF = 'h3FF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WRITE,
      ST_READ,
      ST_WAIT_RD,
      ST_DONE
   } stack_state_e;

endpackage

// File: rtl/stack_ptr.sv
// Stack occupancy counter. With STACK_CHECK_EN defined it saturates at DEPTH via
// the caller's checks and reports full; otherwise it counts modulo DEPTH.
module stack_ptr
   import stack_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   inc,
   input  logic                   dec,
   input  logic                   clr,
   output logic [$clog2(DEPTH):0] level,
   output logic                   empty,
   output logic                   full
);

   localparam int LVL_W = $clog2(DEPTH) + 1;

   logic [LVL_W-1:0] level_q;
   logic [LVL_W-1:0] level_d;

   always_comb begin
      level_d = level_q;
      if (clr) begin
         level_d = '0;
      end else if (inc) begin
`ifdef STACK_CHECK_EN
         level_d = level_q + 1'b1;
`else
         level_d = (level_q + 1'b1) & LVL_W'(DEPTH - 1);
`endif
      end else if (dec) begin
`ifdef STACK_CHECK_EN
         level_d = level_q - 1'b1;
`else
         level_d = (level_q - 1'b1) & LVL_W'(DEPTH - 1);
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) level_q <= '0;
      else     level_q <= level_d;
   end

   assign level = level_q;
   assign empty = (level_q == '0);
`ifdef STACK_CHECK_EN
   assign full  = (level_q == LVL_W'(DEPTH));
`else
   assign full  = 1'b0;
`endif

endmodule

// File: rtl/stack_ctrl.sv
// Descending-stack sequencer: turns push/pop requests into memory write/read cycles.
// Define STACK_CHECK_EN to enable overflow/underflow detection (err, full).
module stack_ctrl
   import stack_pkg::*;
#(
   parameter int                DATA_W     = DATA_W_DEF,
   parameter int                ADDR_W     = ADDR_W_DEF,
   parameter logic [ADDR_W-1:0] STACK_BASE = ADDR_W'(STACK_BASE_DEF),
   parameter int                DEPTH      = DEPTH_DEF
) (
   input  logic                   clk,
   input  logic                   rst_b,
   input  logic                   push_req,
   input  logic [DATA_W-1:0]      push_data,
   input  logic                   pop_req,
   input  logic                   clear,
   input  logic [DATA_W-1:0]      mem_rdata,
   output logic                   mem_we,
   output logic                   mem_re,
   output logic [ADDR_W-1:0]      mem_addr,
   output logic [DATA_W-1:0]      mem_wdata,
   output logic [DATA_W-1:0]      pop_out,
   output logic                   push_done,
   output logic                   pop_done,
   output logic [$clog2(DEPTH):0] level,
   output logic                   empty,
   output logic                   full,
   output logic                   err,
   output stack_state_e           state_dbg
);

   localparam int LVL_W = $clog2(DEPTH) + 1;
`ifdef STACK_CHECK_EN
   localparam bit CHECK_EN = 1'b1;
`else
   localparam bit CHECK_EN = 1'b0;
`endif

   stack_state_e      state_q, state_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [DATA_W-1:0] pop_out_q, pop_out_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic              re_q, re_d;
   logic              push_done_q, push_done_d;
   logic              pop_done_q, pop_done_d;
   logic              err_q, err_d;
   logic              ptr_inc, ptr_dec, ptr_clr;
   logic [LVL_W-1:0]  top_idx;
   logic [ADDR_W-1:0] push_addr, pop_addr;

   stack_ptr #(.DEPTH(DEPTH)) u_ptr (
      .clk   (clk),
      .rst   (rst_b),
      .inc   (ptr_inc),
      .dec   (ptr_dec),
      .clr   (ptr_clr),
      .level (level),
      .empty (empty),
      .full  (full)
   );

   // Masking keeps the top-of-stack index inside the DEPTH window when level wraps.
   assign top_idx   = (level - 1'b1) & LVL_W'(DEPTH - 1);
   assign push_addr = STACK_BASE - ADDR_W'(level);
   assign pop_addr  = STACK_BASE - ADDR_W'(top_idx);

   always_comb begin
      state_d     = state_q;
      data_d      = data_q;
      pop_out_d   = pop_out_q;
      addr_d      = '0;
      we_d        = 1'b0;
      re_d        = 1'b0;
      push_done_d = 1'b0;
      pop_done_d  = 1'b0;
      err_d       = 1'b0;
      ptr_inc     = 1'b0;
      ptr_dec     = 1'b0;
      ptr_clr     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (clear) begin
               ptr_clr = 1'b1;
            end else if (push_req) begin
               data_d = push_data;
               if (CHECK_EN && full) begin
                  state_d     = ST_DONE;
                  push_done_d = 1'b1;
                  err_d       = 1'b1;
               end else begin
                  state_d = ST_WRITE;
                  we_d    = 1'b1;
                  addr_d  = push_addr;
               end
            end else if (pop_req) begin
               if (CHECK_EN && empty) begin
                  state_d    = ST_DONE;
                  pop_done_d = 1'b1;
                  err_d      = 1'b1;
               end else begin
                  state_d = ST_READ;
                  re_d    = 1'b1;
                  addr_d  = pop_addr;
               end
            end
         end
         ST_WRITE: begin
            ptr_inc     = 1'b1;
            push_done_d = 1'b1;
            state_d     = ST_DONE;
         end
         ST_READ: begin
            ptr_dec = 1'b1;
            state_d = ST_WAIT_RD;
         end
         ST_WAIT_RD: begin
            pop_out_d  = mem_rdata;
            pop_done_d = 1'b1;
            state_d    = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Outputs are registered alongside the state so they line up with it.
   always_ff @(posedge clk or posedge rst_b) begin
      if (rst_b) begin
         state_q     <= ST_IDLE;
         data_q      <= '0;
         pop_out_q   <= '0;
         addr_q      <= '0;
         we_q        <= 1'b0;
         re_q        <= 1'b0;
         push_done_q <= 1'b0;
         pop_done_q  <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         data_q      <= data_d;
         pop_out_q   <= pop_out_d;
         addr_q      <= addr_d;
         we_q        <= we_d;
         re_q        <= re_d;
         push_done_q <= push_done_d;
         pop_done_q  <= pop_done_d;
         err_q       <= err_d;
      end
   end

   assign mem_we    = we_q;
   assign mem_re    = re_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = data_q;
   assign pop_out   = pop_out_q;
   assign push_done = push_done_q;
   assign pop_done  = pop_done_q;
   assign err       = err_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed and randomized bench for stack_ctrl against a queue-based stack model
// and a simple synchronous memory model.
module tb_stack_ctrl;
   import stack_pkg::*;

`ifdef STACK_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif
   localparam int DEPTH = 64;

   logic         clk = 1'b0;
   logic         rst_b;
   logic         push_req, pop_req, clear;
   logic [15:0]  push_data;
   logic [15:0]  mem_rdata;
   logic         mem_we, mem_re;
   logic [9:0]   mem_addr;
   logic [15:0]  mem_wdata, pop_out;
   logic         push_done, pop_done, empty, full, err;
   logic [6:0]   level;
   stack_state_e state_dbg;

   int           checks = 0;
   int           errors = 0;
   logic [15:0]  mem [0:1023];
   logic [15:0]  stk [$];
   logic [15:0]  last_pop;
   logic [9:0]   last_waddr;

   stack_ctrl dut (
      .clk       (clk),
      .rst_b     (rst_b),
      .push_req  (push_req),
      .push_data (push_data),
      .pop_req   (pop_req),
      .clear     (clear),
      .mem_rdata (mem_rdata),
      .mem_we    (mem_we),
      .mem_re    (mem_re),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .pop_out   (pop_out),
      .push_done (push_done),
      .pop_done  (pop_done),
      .level     (level),
      .empty     (empty),
      .full      (full),
      .err       (err),
      .state_dbg (state_dbg)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= mem[mem_addr];
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int exp_level();
      return CHK ? stk.size() : stk.size() % DEPTH;
   endfunction

   task automatic chk_flags(input string tag);
      int l;
      l = exp_level();
      chk({tag, "_level"}, 32'(level), 32'(l));
      chk({tag, "_empty"}, 32'(empty), 32'(l == 0));
      chk({tag, "_full"},  32'(full),  32'(CHK && l == DEPTH));
   endtask

   task automatic push_op(input logic [15:0] d);
      int sz, lat, wr, rd, errs;
      bit ovf;
      logic [9:0]  eaddr, waddr;
      logic [15:0] wdat;
      sz    = stk.size();
      ovf   = CHK && (sz == DEPTH);
      eaddr = 10'h3FF - 10'(sz % DEPTH);
      lat = 0; wr = 0; rd = 0; errs = 0; waddr = '0; wdat = '0;
      push_data = d;
      push_req  = 1'b1;
      for (int n = 1; n <= 8; n++) begin
         tick();
         if (mem_we) begin wr++; waddr = mem_addr; wdat = mem_wdata; end
         if (mem_re || pop_done) rd++;
         if (err) errs++;
         if (push_done) begin lat = n; break; end
      end
      push_req = 1'b0;
      if (!ovf) stk.push_back(d);
      last_waddr = waddr;
      chk("push_latency", 32'(lat), ovf ? 32'd1 : 32'd2);
      chk("push_writes", 32'(wr), ovf ? 32'd0 : 32'd1);
      chk("push_no_read", 32'(rd), 32'd0);
      chk("push_err", 32'(errs), 32'(ovf));
      if (wr == 1) begin
         chk("push_addr", 32'(waddr), 32'(eaddr));
         chk("push_wdata", 32'(wdat), 32'(d));
      end
      chk_flags("push");
      tick();
      chk("push_idle", 32'(state_dbg), 32'(ST_IDLE));
   endtask

   task automatic pop_op;
      int sz, lat, rd, wr, errs;
      bit und;
      logic [9:0]  eaddr, raddr;
      logic [15:0] eout;
      sz    = stk.size();
      und   = CHK && (sz == 0);
      eaddr = 10'h3FF - 10'((sz - 1) % DEPTH);
      lat = 0; rd = 0; wr = 0; errs = 0; raddr = '0;
      pop_req = 1'b1;
      for (int n = 1; n <= 8; n++) begin
         tick();
         if (mem_re) begin rd++; raddr = mem_addr; end
         if (mem_we || push_done) wr++;
         if (err) errs++;
         if (pop_done) begin lat = n; break; end
      end
      pop_req = 1'b0;
      if (und) begin
         eout = last_pop;
      end else begin
         eout = stk.pop_back();
         last_pop = eout;
      end
      chk("pop_latency", 32'(lat), und ? 32'd1 : 32'd3);
      chk("pop_reads", 32'(rd), und ? 32'd0 : 32'd1);
      chk("pop_no_write", 32'(wr), 32'd0);
      chk("pop_err", 32'(errs), 32'(und));
      if (rd == 1) chk("pop_addr", 32'(raddr), 32'(eaddr));
      chk("pop_out", 32'(pop_out), 32'(eout));
      chk_flags("pop");
      tick();
      chk("pop_idle", 32'(state_dbg), 32'(ST_IDLE));
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_we"}, 32'(mem_we), 32'd0);
      chk({tag, "_re"}, 32'(mem_re), 32'd0);
      chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
      chk({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
      chk({tag, "_pop_out"}, 32'(pop_out), 32'd0);
      chk({tag, "_push_done"}, 32'(push_done), 32'd0);
      chk({tag, "_pop_done"}, 32'(pop_done), 32'd0);
      chk({tag, "_level"}, 32'(level), 32'd0);
      chk({tag, "_empty"}, 32'(empty), 32'd1);
      chk({tag, "_full"}, 32'(full), 32'd0);
      chk({tag, "_err"}, 32'(err), 32'd0);
      chk({tag, "_state"}, 32'(state_dbg), 32'(ST_IDLE));
   endtask

   initial begin
      int pd;
      push_req = 0; pop_req = 0; clear = 0; push_data = '0; mem_rdata = '0;
      last_pop = '0; last_waddr = '0;
      rst_b = 1'b0;
      #1 rst_b = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_values("rst_held");
      rst_b = 1'b0;
      tick();
      chk_reset_values("rst_released");

      // Single round trip
      push_op(16'hBEEF);
      chk("rt_push_addr", 32'(last_waddr), 32'h3FF);
      pop_op();
      chk("rt_pop_out", 32'(pop_out), 32'hBEEF);
      chk("rt_level", 32'(level), 32'd0);

      // LIFO order
      push_op(16'd1); push_op(16'd2); push_op(16'd3);
      pop_op(); chk("lifo_0", 32'(pop_out), 32'd3);
      pop_op(); chk("lifo_1", 32'(pop_out), 32'd2);
      pop_op(); chk("lifo_2", 32'(pop_out), 32'd1);
      chk("lifo_empty", 32'(empty), 32'd1);

      // Simultaneous requests: push first, then the pop sees the pushed word
      push_op(16'h7777);
      pop_req = 1'b1;
      push_op(16'h5A5A);
      pop_op();
      chk("simul_pop_out", 32'(pop_out), 32'h5A5A);
      pop_op();

      // Randomized traffic kept below capacity
      for (int i = 0; i < 120; i++) begin
         int r;
         r = $urandom_range(0, 2);
         if (stk.size() == 0 || (r != 0 && stk.size() < DEPTH - 1)) push_op(16'($urandom));
         else pop_op();
      end
      while (stk.size() > 0) pop_op();

      // Clear
      for (int i = 0; i < 5; i++) push_op(16'($urandom));
      clear = 1'b1;
      tick();
      clear = 1'b0;
      stk.delete();
      chk_flags("clear");
      push_op(16'h0C0C);
      chk("clear_next_addr", 32'(last_waddr), 32'h3FF);

      // Capacity boundary
      clear = 1'b1; tick(); clear = 1'b0;
      stk.delete();
      for (int i = 0; i < DEPTH; i++) push_op(16'($urandom));
`ifdef STACK_CHECK_EN
      chk("cap_full", 32'(full), 32'd1);
      push_op(16'hDEAD);
      for (int i = 0; i < DEPTH; i++) pop_op();
      pop_op();
`else
      chk("wrap_level", 32'(level), 32'd0);
      push_op(16'h1111);
      chk("wrap_addr", 32'(last_waddr), 32'h3FF);
      clear = 1'b1; tick(); clear = 1'b0;
      stk.delete();
`endif

      // Reset during WAIT_RD
      push_op(16'h1234);
      pop_req = 1'b1;
      tick();
      tick();
      chk("mid_state", 32'(state_dbg), 32'(ST_WAIT_RD));
      #2 rst_b = 1'b1;
      #1;
      chk("mid_pop_done", 32'(pop_done), 32'd0);
      chk("mid_level", 32'(level), 32'd0);
      chk("mid_pop_out", 32'(pop_out), 32'd0);
      chk("mid_empty", 32'(empty), 32'd1);
      @(posedge clk);
      #1;
      rst_b = 1'b0;
      pop_req = 1'b0;
      pd = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (pop_done) pd++;
      end
      chk("mid_no_done", 32'(pd), 32'd0);
      stk.delete();
      last_pop = '0;
      push_op(16'hCAFE);
      chk("mid_next_addr", 32'(last_waddr), 32'h3FF);
      pop_op();
      chk("mid_next_pop", 32'(pop_out), 32'hCAFE);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
